// File: rtl/alu_seq_ctrl.sv
// Multi-cycle instruction sequencer for a register-file ALU datapath.
// It takes one 16-bit instruction, decodes it, waits one ALU settle cycle, then writes back.
module alu_seq_ctrl #(
  parameter logic [4:0]  CMP_OPCODE = 5'b01011,
  parameter logic [15:0] NOP_INST   = 16'h0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        InstValid,
  input  logic [15:0] Inst,
  output logic        InstReady,
  output logic [3:0]  RdestRegLoc,
  output logic [3:0]  RsrcRegLoc,
  output logic [15:0] Imm,
  output logic        Imm_s,
  output logic [4:0]  OpCode,
  output logic        En,
  input  logic [4:0]  AluFlags,
  output logic [4:0]  FlagsReg,
  output logic        Done,
  output logic        Busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_inst;
  logic        r_nop;
  logic [3:0]  r_rdest;
  logic [3:0]  r_rsrc;
  logic [15:0] r_imm;
  logic        r_imm_s;
  logic [4:0]  r_opcode;
  logic [4:0]  r_flags;
  logic        w_accept;
  logic        w_decode;
  logic        w_wb;
  logic        w_reg_form;
  logic [15:0] w_imm_sext;

  assign w_reg_form = (r_inst[15:12] == 4'h0);
  assign w_imm_sext = {{8{r_inst[7]}}, r_inst[7:0]};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_decode     = 1'b0;
    w_wb         = 1'b0;
    InstReady    = 1'b0;
    Done         = 1'b0;
    case (r_state)
      IDLE: begin
        InstReady = 1'b1;
        if (InstValid) begin
          w_accept     = 1'b1;
          w_state_next = DECODE;
        end
      end
      DECODE: begin
        w_decode     = 1'b1;
        w_state_next = EXEC;
      end
      EXEC: begin
        w_state_next = WB;
      end
      WB: begin
        w_wb         = 1'b1;
        Done         = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Operand registers change only in DECODE, so they hold through EXEC, WB and IDLE.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_inst   <= 16'h0000;
      r_nop    <= 1'b0;
      r_rdest  <= 4'h0;
      r_rsrc   <= 4'h0;
      r_imm    <= 16'h0000;
      r_imm_s  <= 1'b0;
      r_opcode <= 5'b00000;
      r_flags  <= 5'b00000;
    end else begin
      if (w_accept) begin
        r_inst <= Inst;
      end
      if (w_decode) begin
        r_nop   <= (r_inst == NOP_INST);
        r_rdest <= r_inst[11:8];
        if (w_reg_form) begin
          r_opcode <= {1'b0, r_inst[7:4]};
          r_rsrc   <= r_inst[3:0];
          r_imm    <= 16'h0000;
          r_imm_s  <= 1'b0;
        end else begin
          r_opcode <= {1'b0, r_inst[15:12]};
          r_rsrc   <= 4'h0;
          r_imm    <= w_imm_sext;
          r_imm_s  <= 1'b1;
        end
      end
      if (w_wb && !r_nop) begin
        r_flags <= AluFlags;
      end
    end
  end

  assign En          = w_wb & ~r_nop & (r_opcode != CMP_OPCODE);
  assign Busy        = ~InstReady;
  assign RdestRegLoc = r_rdest;
  assign RsrcRegLoc  = r_rsrc;
  assign Imm         = r_imm;
  assign Imm_s       = r_imm_s;
  assign OpCode      = r_opcode;
  assign FlagsReg    = r_flags;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized self-checking bench for alu_seq_ctrl against a behavioural decode/flags model.
module tb_alu_seq_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        InstValid = 1'b0;
  logic [15:0] Inst = 16'h0000;
  logic [4:0]  AluFlags = 5'b00000;
  logic        InstReady;
  logic [3:0]  RdestRegLoc;
  logic [3:0]  RsrcRegLoc;
  logic [15:0] Imm;
  logic        Imm_s;
  logic [4:0]  OpCode;
  logic        En;
  logic [4:0]  FlagsReg;
  logic        Done;
  logic        Busy;

  int total = 0;
  int bad = 0;
  logic [4:0] model_flags = 5'b00000;
  localparam logic [4:0] CMP = 5'b01011;

  alu_seq_ctrl dut (
    .Clk(Clk), .Rst(Rst), .InstValid(InstValid), .Inst(Inst), .InstReady(InstReady),
    .RdestRegLoc(RdestRegLoc), .RsrcRegLoc(RsrcRegLoc), .Imm(Imm), .Imm_s(Imm_s),
    .OpCode(OpCode), .En(En), .AluFlags(AluFlags), .FlagsReg(FlagsReg), .Done(Done), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0]  opcode;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic [15:0] imm;
    logic        imm_s;
    logic        writes;
  } exp_t;

  typedef struct {
    logic        ready_pre, busy_dec, done_dec, en_dec, done_exec, en_exec;
    logic [4:0]  opcode_exec, opcode_wb;
    logic [3:0]  rdest, rsrc;
    logic [15:0] imm;
    logic        imm_s, done_wb, en_wb, ready_wb;
    logic [4:0]  flags_wb, flags_after, opcode_after;
    logic        ready_after, done_after, en_after;
  } obs_t;

  // Field extraction by plain arithmetic on the instruction value.
  function automatic exp_t model(input logic [15:0] w);
    exp_t e;
    int word, major, lo;
    word    = int'(w);
    major   = word / 4096;
    lo      = word % 256;
    e.rdest = 4'((word / 256) % 16);
    if (major == 0) begin
      e.opcode = 5'((word / 16) % 16);
      e.rsrc   = 4'(word % 16);
      e.imm    = 16'h0000;
      e.imm_s  = 1'b0;
    end else begin
      e.opcode = 5'(major);
      e.rsrc   = 4'h0;
      e.imm    = 16'((lo >= 128) ? lo + 65280 : lo);
      e.imm_s  = 1'b1;
    end
    e.writes = (w != 16'h0000) && (e.opcode != CMP);
    return e;
  endfunction

  // Offers one instruction from IDLE and samples every phase of its execution.
  task automatic run_inst(input logic [15:0] w, input logic [4:0] flags, output obs_t o);
    @(negedge Clk);
    o.ready_pre = InstReady;
    InstValid = 1'b1;
    Inst      = w;
    AluFlags  = flags;
    @(posedge Clk);
    #1;
    InstValid = 1'b0;
    Inst      = 16'($urandom);
    @(negedge Clk);
    o.busy_dec = Busy; o.done_dec = Done; o.en_dec = En;
    @(negedge Clk);
    o.done_exec = Done; o.en_exec = En; o.opcode_exec = OpCode;
    @(negedge Clk);
    o.opcode_wb = OpCode; o.rdest = RdestRegLoc; o.rsrc = RsrcRegLoc; o.imm = Imm; o.imm_s = Imm_s;
    o.done_wb = Done; o.en_wb = En; o.ready_wb = InstReady; o.flags_wb = FlagsReg;
    @(negedge Clk);
    o.flags_after = FlagsReg; o.ready_after = InstReady; o.done_after = Done;
    o.en_after = En; o.opcode_after = OpCode;
    $display("txn inst=%h flags_in=%b opcode=%h rd=%h rs=%h imm=%h imm_s=%b done=%b en=%b flags_out=%b",
             w, flags, o.opcode_wb, o.rdest, o.rsrc, o.imm, o.imm_s, o.done_wb, o.en_wb, o.flags_after);
  endtask

  task automatic test_reset();
    #1 Rst = 1'b1;
    #1;
    total++; if (InstReady !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", InstReady); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Busy); end
    total++; if ({En, Done} !== 2'b00) begin bad++; $display("FAIL reset_en_done got=%b want=00", {En, Done}); end
    total++; if ({OpCode, RdestRegLoc, RsrcRegLoc, Imm, Imm_s, FlagsReg} !== 35'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {OpCode, RdestRegLoc, RsrcRegLoc, Imm, Imm_s, FlagsReg});
    end
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    $display("txn reset released");
  endtask

  task automatic test_register();
    obs_t o;
    exp_t e;
    e = model(16'h0352);
    run_inst(16'h0352, 5'b00110, o);
    total++; if (o.ready_pre !== 1'b1) begin bad++; $display("FAIL reg_ready_pre got=%b want=1", o.ready_pre); end
    total++; if (o.busy_dec !== 1'b1) begin bad++; $display("FAIL reg_busy got=%b want=1", o.busy_dec); end
    total++; if ({o.done_dec, o.en_dec, o.done_exec, o.en_exec} !== 4'b0000) begin
      bad++; $display("FAIL reg_early_pulse got=%b want=0000", {o.done_dec, o.en_dec, o.done_exec, o.en_exec});
    end
    total++; if (o.opcode_exec !== 5'b00101) begin bad++; $display("FAIL reg_opcode got=%b want=00101", o.opcode_exec); end
    total++; if (o.rdest !== e.rdest || o.rsrc !== e.rsrc) begin
      bad++; $display("FAIL reg_regs got=%h/%h want=%h/%h", o.rdest, o.rsrc, e.rdest, e.rsrc);
    end
    total++; if (o.imm_s !== 1'b0 || o.imm !== 16'h0000) begin bad++; $display("FAIL reg_imm got=%b/%h want=0/0000", o.imm_s, o.imm); end
    total++; if ({o.done_wb, o.en_wb, o.ready_wb} !== 3'b110) begin
      bad++; $display("FAIL reg_wb got=%b want=110", {o.done_wb, o.en_wb, o.ready_wb});
    end
    total++; if (o.flags_wb !== model_flags) begin bad++; $display("FAIL reg_flags_early got=%b want=%b", o.flags_wb, model_flags); end
    model_flags = 5'b00110;
    total++; if (o.flags_after !== model_flags) begin bad++; $display("FAIL reg_flags got=%b want=%b", o.flags_after, model_flags); end
    total++; if ({o.ready_after, o.done_after, o.en_after} !== 3'b100) begin
      bad++; $display("FAIL reg_idle got=%b want=100", {o.ready_after, o.done_after, o.en_after});
    end
    total++; if (o.opcode_after !== e.opcode) begin bad++; $display("FAIL reg_hold got=%h want=%h", o.opcode_after, e.opcode); end
  endtask

  task automatic test_immediate();
    obs_t o;
    run_inst(16'h51F6, 5'b01001, o);
    total++; if (o.opcode_wb !== 5'b00101 || o.rdest !== 4'h1) begin
      bad++; $display("FAIL imm_decode got=%b/%h want=00101/1", o.opcode_wb, o.rdest);
    end
    total++; if (o.imm !== 16'hFFF6 || o.imm_s !== 1'b1 || o.rsrc !== 4'h0) begin
      bad++; $display("FAIL imm_operand got=%h/%b/%h want=fff6/1/0", o.imm, o.imm_s, o.rsrc);
    end
    total++; if ({o.en_dec, o.en_exec, o.en_wb, o.en_after} !== 4'b0010) begin
      bad++; $display("FAIL imm_en got=%b want=0010", {o.en_dec, o.en_exec, o.en_wb, o.en_after});
    end
    model_flags = 5'b01001;
  endtask

  task automatic test_compare();
    obs_t o;
    logic [15:0] cmp_words [2];
    cmp_words[0] = 16'h04B1;
    cmp_words[1] = 16'hB47F;
    for (int i = 0; i < 2; i++) begin
      run_inst(cmp_words[i], 5'b10010 ^ 5'(i), o);
      total++; if (o.opcode_wb !== CMP) begin bad++; $display("FAIL cmp_opcode got=%b want=%b", o.opcode_wb, CMP); end
      total++; if ({o.en_dec, o.en_exec, o.en_wb, o.en_after} !== 4'b0000) begin
        bad++; $display("FAIL cmp_en got=%b want=0000", {o.en_dec, o.en_exec, o.en_wb, o.en_after});
      end
      total++; if (o.done_wb !== 1'b1) begin bad++; $display("FAIL cmp_done got=%b want=1", o.done_wb); end
      model_flags = 5'b10010 ^ 5'(i);
      total++; if (o.flags_after !== model_flags) begin bad++; $display("FAIL cmp_flags got=%b want=%b", o.flags_after, model_flags); end
    end
  endtask

  task automatic test_nop();
    obs_t o;
    run_inst(16'h0000, ~model_flags, o);
    total++; if (o.done_wb !== 1'b1 || o.done_exec !== 1'b0) begin
      bad++; $display("FAIL nop_done got=%b%b want=01", o.done_exec, o.done_wb);
    end
    total++; if ({o.en_dec, o.en_exec, o.en_wb, o.en_after} !== 4'b0000) begin
      bad++; $display("FAIL nop_en got=%b want=0000", {o.en_dec, o.en_exec, o.en_wb, o.en_after});
    end
    total++; if (o.flags_after !== model_flags) begin bad++; $display("FAIL nop_flags got=%b want=%b", o.flags_after, model_flags); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] i1, i2;
    logic [9:0]  done_v, rdy_v, exp_done, exp_rdy;
    logic [4:0]  op_v [10];
    exp_t e1, e2;
    i1 = 16'h3104;
    i2 = 16'h0A93;
    e1 = model(i1);
    e2 = model(i2);
    @(negedge Clk);
    InstValid = 1'b1; Inst = i1; AluFlags = 5'b00101;
    @(posedge Clk);
    #1 Inst = i2;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      done_v[c] = Done; rdy_v[c] = InstReady; op_v[c] = OpCode;
      exp_done[c] = (c % 4 == 2) && (c < 8);
      exp_rdy[c]  = (c % 4 == 3) || (c >= 7);
      if (c == 4) InstValid = 1'b0;
    end
    $display("txn back_to_back done=%b ready=%b", done_v, rdy_v);
    total++; if (done_v !== exp_done) begin bad++; $display("FAIL b2b_done got=%b want=%b", done_v, exp_done); end
    total++; if (rdy_v !== exp_rdy) begin bad++; $display("FAIL b2b_ready got=%b want=%b", rdy_v, exp_rdy); end
    total++; if (op_v[1] !== e1.opcode || op_v[3] !== e1.opcode) begin
      bad++; $display("FAIL b2b_first got=%h/%h want=%h", op_v[1], op_v[3], e1.opcode);
    end
    total++; if (op_v[5] !== e2.opcode) begin bad++; $display("FAIL b2b_second got=%h want=%h", op_v[5], e2.opcode); end
    model_flags = 5'b00101;
  endtask

  task automatic test_reset_in_wb();
    obs_t o;
    exp_t e;
    e = model(16'h0352);
    @(negedge Clk);
    InstValid = 1'b1; Inst = 16'h2A7C; AluFlags = 5'b11111;
    @(posedge Clk);
    #1 InstValid = 1'b0;
    repeat (3) @(negedge Clk);
    total++; if ({Done, En} !== 2'b11) begin bad++; $display("FAIL rstwb_pre got=%b want=11", {Done, En}); end
    #2 Rst = 1'b1;
    #1;
    total++; if ({Done, En} !== 2'b00) begin bad++; $display("FAIL rstwb_drop got=%b want=00", {Done, En}); end
    total++; if ({InstReady, Busy} !== 2'b10) begin bad++; $display("FAIL rstwb_idle got=%b want=10", {InstReady, Busy}); end
    total++; if ({FlagsReg, OpCode, RdestRegLoc, Imm, Imm_s} !== 31'h0) begin
      bad++; $display("FAIL rstwb_clear got=%h want=0", {FlagsReg, OpCode, RdestRegLoc, Imm, Imm_s});
    end
    @(negedge Clk);
    Rst = 1'b0;
    model_flags = 5'b00000;
    @(negedge Clk);
    total++; if ({FlagsReg, Done} !== 6'h0) begin bad++; $display("FAIL rstwb_after got=%h want=0", {FlagsReg, Done}); end
    $display("txn reset during writeback");
    run_inst(16'h0352, 5'b01110, o);
    total++; if (o.opcode_wb !== e.opcode || o.en_wb !== 1'b1) begin
      bad++; $display("FAIL rstwb_resume got=%h/%b want=%h/1", o.opcode_wb, o.en_wb, e.opcode);
    end
    model_flags = 5'b01110;
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [15:0] w;
    logic [4:0]  f;
    for (int n = 0; n < 40; n++) begin
      w = 16'($urandom);
      case ($urandom_range(0, 4))
        0: w = 16'h0000;
        1: w = {4'h0, w[11:8], 4'hB, w[3:0]};
        2: w = {4'hB, w[11:0]};
        default: ;
      endcase
      f = 5'($urandom);
      e = model(w);
      run_inst(w, f, o);
      total++; if (o.opcode_exec !== e.opcode || o.opcode_wb !== e.opcode) begin
        bad++; $display("FAIL rnd_opcode inst=%h got=%h/%h want=%h", w, o.opcode_exec, o.opcode_wb, e.opcode);
      end
      total++; if (o.rdest !== e.rdest || o.rsrc !== e.rsrc) begin
        bad++; $display("FAIL rnd_regs inst=%h got=%h/%h want=%h/%h", w, o.rdest, o.rsrc, e.rdest, e.rsrc);
      end
      total++; if (o.imm !== e.imm || o.imm_s !== e.imm_s) begin
        bad++; $display("FAIL rnd_imm inst=%h got=%h/%b want=%h/%b", w, o.imm, o.imm_s, e.imm, e.imm_s);
      end
      total++; if ({o.en_dec, o.en_exec, o.en_wb, o.en_after} !== {2'b00, e.writes, 1'b0}) begin
        bad++; $display("FAIL rnd_en inst=%h got=%b want=00%b0", w, {o.en_dec, o.en_exec, o.en_wb, o.en_after}, e.writes);
      end
      total++; if ({o.done_dec, o.done_exec, o.done_wb, o.done_after} !== 4'b0010) begin
        bad++; $display("FAIL rnd_done inst=%h got=%b want=0010", w, {o.done_dec, o.done_exec, o.done_wb, o.done_after});
      end
      if (w != 16'h0000) model_flags = f;
      total++; if (o.flags_after !== model_flags) begin
        bad++; $display("FAIL rnd_flags inst=%h got=%b want=%b", w, o.flags_after, model_flags);
      end
    end
  endtask

  initial begin
    test_reset();
    test_register();
    test_immediate();
    test_compare();
    test_nop();
    test_back_to_back();
    test_reset_in_wb();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
